// File: rtl/micro_sequencer_if.sv
// Sequencer control/status bundle between the decoder/control store and the
// microprogram sequencer.
interface micro_sequencer_if #(
  parameter int unsigned AW = 5
);
  logic [AW-1:0] ib;
  logic [AW-1:0] sb;
  logic [2:0]    nxt_sel;
  logic [AW-1:0] br_addr;
  logic          zflag;
  logic          stall;
  logic          resume;
  logic [AW-1:0] uaddr;
  logic          ir_load;
  logic          halted;
  logic          fault;

  // Decoder / control-store side
  modport master (
    output ib, sb, nxt_sel, br_addr, zflag, stall, resume,
    input  uaddr, ir_load, halted, fault
  );

  // Sequencer side
  modport slave (
    input  ib, sb, nxt_sel, br_addr, zflag, stall, resume,
    output uaddr, ir_load, halted, fault
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered micro-address generation with dispatch,
// conditional branch, one-level call/return, halt/resume and a runaway
// watchdog that faults when FETCH_ADDR is not revisited in time.
module micro_sequencer #(
  parameter int unsigned   AW         = 5,
  parameter logic [AW-1:0] FETCH_ADDR = '0,
  parameter int unsigned   MAX_STEPS  = 16
) (
  input logic               clk,
  input logic               rst,
  micro_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    SEL_SEQ     = 3'b000,
    SEL_DISP_IB = 3'b001,
    SEL_DISP_SB = 3'b010,
    SEL_BZ      = 3'b011,
    SEL_JMP     = 3'b100,
    SEL_CALL    = 3'b101,
    SEL_RET     = 3'b110,
    SEL_HALT    = 3'b111
  } sel_t;

  state_t        state_q, state_d;
  logic [AW-1:0] uaddr_q, uaddr_d;
  logic [AW-1:0] link_q, link_d;
  logic          link_valid_q, link_valid_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;

  logic [AW-1:0] addr_inc;
  logic [AW-1:0] target;
  logic          take_fault;
  logic          halt_req;

  assign addr_inc = uaddr_q + 1'b1;

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      uaddr_q      <= FETCH_ADDR;
      link_q       <= '0;
      link_valid_q <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      uaddr_q      <= uaddr_d;
      link_q       <= link_d;
      link_valid_q <= link_valid_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  // Next-address selection, watchdog and state transitions.
  // The candidate address is computed first so the watchdog can judge it;
  // any fault then discards the whole update and freezes the registers.
  always_comb begin
    state_d      = state_q;
    uaddr_d      = uaddr_q;
    link_d       = link_q;
    link_valid_d = link_valid_q;
    step_cnt_d   = step_cnt_q;
    target       = uaddr_q;
    take_fault   = 1'b0;
    halt_req     = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (!bus.stall) begin
          unique case (sel_t'(bus.nxt_sel))
            SEL_SEQ:     target = addr_inc;
            SEL_DISP_IB: target = bus.ib;
            SEL_DISP_SB: target = bus.sb;
            SEL_BZ:      target = bus.zflag ? bus.br_addr : addr_inc;
            SEL_JMP:     target = bus.br_addr;
            SEL_CALL: begin
              if (link_valid_q) begin
                take_fault = 1'b1;
              end else begin
                target       = bus.br_addr;
                link_d       = addr_inc;
                link_valid_d = 1'b1;
              end
            end
            SEL_RET: begin
              if (!link_valid_q) begin
                take_fault = 1'b1;
              end else begin
                target       = link_q;
                link_valid_d = 1'b0;
              end
            end
            SEL_HALT: halt_req = 1'b1;
            default:  target = uaddr_q;
          endcase

          if (target == FETCH_ADDR) begin
            step_cnt_d = '0;
          end else if (step_cnt_q == CW'(MAX_STEPS - 1)) begin
            take_fault = 1'b1;
          end else if (step_cnt_q != '1) begin
            step_cnt_d = step_cnt_q + 1'b1;
          end

          if (take_fault) begin
            state_d      = S_FAULT;
            uaddr_d      = uaddr_q;
            link_d       = link_q;
            link_valid_d = link_valid_q;
            step_cnt_d   = step_cnt_q;
          end else begin
            uaddr_d = target;
            if (halt_req) begin
              state_d = S_HALT;
            end
          end
        end
      end
      S_HALT: begin
        if (bus.resume) begin
          state_d      = S_RUN;
          uaddr_d      = FETCH_ADDR;
          step_cnt_d   = '0;
          link_valid_d = 1'b0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign bus.uaddr   = uaddr_q;
  assign bus.ir_load = (state_q == S_RUN) && (uaddr_q == FETCH_ADDR) && !bus.stall;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expected values.
module tb_micro_sequencer;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  micro_sequencer_if #(.AW(5)) bus ();

  micro_sequencer #(
    .AW         (5),
    .FETCH_ADDR (5'd0),
    .MAX_STEPS  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.ib      = '0;
    bus.sb      = '0;
    bus.nxt_sel = 3'b000;
    bus.br_addr = '0;
    bus.zflag   = 1'b0;
    bus.stall   = 1'b0;
    bus.resume  = 1'b0;
    cyc();
    do_reset();

    // Reset state
    check("rst_uaddr",   32'(bus.uaddr), 0);
    check("rst_irload",  32'(bus.ir_load), 1);
    check("rst_halted",  32'(bus.halted), 0);
    check("rst_fault",   32'(bus.fault), 0);

    // Dispatch, sequence, branch-on-zero
    bus.nxt_sel = 3'b001; bus.ib = 5'd5; cyc();
    check("disp_ib", 32'(bus.uaddr), 5);
    check("disp_ib_irload", 32'(bus.ir_load), 0);
    bus.nxt_sel = 3'b000; cyc();
    check("seq", 32'(bus.uaddr), 6);
    bus.nxt_sel = 3'b010; bus.sb = 5'd19; cyc();
    check("disp_sb", 32'(bus.uaddr), 19);
    bus.nxt_sel = 3'b011; bus.br_addr = 5'd0; bus.zflag = 1'b0; cyc();
    check("bz_not_taken", 32'(bus.uaddr), 20);
    bus.zflag = 1'b1; cyc();
    check("bz_taken", 32'(bus.uaddr), 0);
    check("bz_irload", 32'(bus.ir_load), 1);
    bus.zflag = 1'b0;

    // Call / return / nested call fault
    bus.nxt_sel = 3'b100; bus.br_addr = 5'd12; cyc();
    check("jmp", 32'(bus.uaddr), 12);
    bus.nxt_sel = 3'b101; bus.br_addr = 5'd25; cyc();
    check("call", 32'(bus.uaddr), 25);
    bus.nxt_sel = 3'b110; cyc();
    check("ret_link", 32'(bus.uaddr), 13);
    bus.nxt_sel = 3'b101; bus.br_addr = 5'd25; cyc();
    check("call2", 32'(bus.uaddr), 25);
    check("call2_nofault", 32'(bus.fault), 0);
    bus.br_addr = 5'd3; cyc();
    check("nested_fault", 32'(bus.fault), 1);
    check("nested_uaddr", 32'(bus.uaddr), 25);
    bus.nxt_sel = 3'b000; cyc();
    check("fault_frozen", 32'(bus.uaddr), 25);
    check("fault_irload", 32'(bus.ir_load), 0);
    do_reset();
    check("clr_fault", 32'(bus.fault), 0);
    check("clr_uaddr", 32'(bus.uaddr), 0);
    bus.nxt_sel = 3'b110; cyc();
    check("ret_fault", 32'(bus.fault), 1);
    check("ret_fault_uaddr", 32'(bus.uaddr), 0);
    check("ret_fault_irload", 32'(bus.ir_load), 0);
    do_reset();

    // Wrap, stall, watchdog
    bus.nxt_sel = 3'b100; bus.br_addr = 5'd31; cyc();
    check("jmp31", 32'(bus.uaddr), 31);
    bus.nxt_sel = 3'b000; cyc();
    check("wrap", 32'(bus.uaddr), 0);
    check("wrap_irload", 32'(bus.ir_load), 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_uaddr", 32'(bus.uaddr), 0);
    end
    check("stall_irload", 32'(bus.ir_load), 0);
    bus.stall = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      check("wd_seq", 32'(bus.uaddr), 32'(i));
    end
    check("wd_nofault15", 32'(bus.fault), 0);
    cyc();
    check("wd_fault", 32'(bus.fault), 1);
    check("wd_uaddr", 32'(bus.uaddr), 15);
    bus.resume = 1'b1; cyc();
    check("fault_resume_ign", 32'(bus.fault), 1);
    check("fault_resume_uaddr", 32'(bus.uaddr), 15);
    bus.resume = 1'b0;
    do_reset();
    check("wd_rst_clear", 32'(bus.fault), 0);

    // Halt / resume
    bus.nxt_sel = 3'b101; bus.br_addr = 5'd9; cyc();
    check("call9", 32'(bus.uaddr), 9);
    bus.nxt_sel = 3'b111; cyc();
    check("halt", 32'(bus.halted), 1);
    check("halt_uaddr", 32'(bus.uaddr), 9);
    bus.nxt_sel = 3'b001; bus.ib = 5'd5;
    for (int i = 0; i < 5; i++) begin
      bus.stall = 1'(i % 2);
      cyc();
      check("halt_hold", 32'(bus.uaddr), 9);
    end
    check("halt_still", 32'(bus.halted), 1);
    bus.resume = 1'b1; bus.stall = 1'b1; bus.nxt_sel = 3'b000; cyc();
    check("resume_uaddr", 32'(bus.uaddr), 0);
    check("resume_halted", 32'(bus.halted), 0);
    check("resume_stall_irload", 32'(bus.ir_load), 0);
    bus.resume = 1'b0; bus.stall = 1'b0; #1;
    check("resume_irload", 32'(bus.ir_load), 1);
    bus.nxt_sel = 3'b101; bus.br_addr = 5'd9; cyc();
    check("resume_lv_clear", 32'(bus.fault), 0);
    check("resume_call", 32'(bus.uaddr), 9);
    bus.resume = 1'b1; bus.nxt_sel = 3'b000; cyc();
    check("run_resume_ign", 32'(bus.uaddr), 10);
    check("run_resume_halted", 32'(bus.halted), 0);
    bus.resume = 1'b0;
    bus.nxt_sel = 3'b100; bus.br_addr = 5'd0; cyc();
    bus.nxt_sel = 3'b111; cyc();
    check("halt0", 32'(bus.halted), 1);
    check("halt0_irload", 32'(bus.ir_load), 0);
    bus.stall = 1'b1;
    do_reset();
    bus.stall = 1'b0; #1;
    check("halt_rst_halted", 32'(bus.halted), 0);
    check("halt_rst_uaddr", 32'(bus.uaddr), 0);
    check("halt_rst_irload", 32'(bus.ir_load), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
